// File: rtl/iic_cfg_sequencer_if.sv
// Byte-level I2C write engine bus: one (slave, reg, data) write per request.
// The sequencer is the master; the write engine is the slave.
interface iic_cfg_sequencer_if;
  logic       eng_req;
  logic [6:0] eng_slave;
  logic [7:0] eng_reg;
  logic [7:0] eng_data;
  logic       eng_done;
  logic       eng_nack;

  modport master (
    output eng_req, eng_slave, eng_reg, eng_data,
    input  eng_done, eng_nack
  );

  modport slave (
    input  eng_req, eng_slave, eng_reg, eng_data,
    output eng_done, eng_nack
  );
endinterface

// File: rtl/iic_cfg_sequencer.sv
// Boot-time HDMI transmitter register programming over a shared I2C write
// engine, with a runtime write port, NACK retry, power-up settling delay and
// hot-plug triggered re-configuration.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for start or an hpd rising edge
// PWR_WAIT  | power-up settling count; hpd loss drops back to IDLE
// TBL_ISSUE | latch table entry at tbl_idx (eng_req low for this cycle)
// TBL_WAIT  | table write in flight, waiting for eng_done
// READY     | table written; runtime writes accepted here only
// USR_WAIT  | runtime write in flight, waiting for eng_done
// USR_RETRY | one-cycle eng_req gap before re-sending a NACKed runtime write
// FAIL      | table write exhausted its retries; cfg_err held
module iic_cfg_sequencer #(
  parameter int         NUM_ENTRIES  = 21,
  parameter logic [6:0] SLAVE_ADDR   = 7'h76,
  parameter int         PWRUP_CYCLES = 40000,
  parameter int         MAX_RETRY    = 3,
  parameter int         IDX_W        = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               hpd,
  output logic [IDX_W-1:0]   tbl_idx,
  input  logic [7:0]         tbl_reg,
  input  logic [7:0]         tbl_data,
  input  logic               usr_req,
  input  logic [7:0]         usr_reg,
  input  logic [7:0]         usr_data,
  output logic               usr_gnt,
  output logic               usr_err,
  iic_cfg_sequencer_if.master eng,
  output logic               cfg_done,
  output logic               cfg_err
);

  localparam int CNT_W = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, PWR_WAIT, TBL_ISSUE, TBL_WAIT, READY, USR_WAIT, USR_RETRY, FAIL
  } state_t;

  state_t state, state_nxt;

  logic             hpd_s1, hpd_s2, hpd_d;
  logic             hpd_rise, trig;
  logic [CNT_W-1:0] cnt;
  logic [RTY_W-1:0] retry;
  logic             pend;
  logic [7:0]       eng_reg_q, eng_data_q;

  logic restart, cnt_inc, ld_tbl, ld_usr, idx_inc;
  logic retry_inc, retry_clr, set_done, set_err, gnt_set, gnt_err, pend_set;

  logic cnt_tc, last_idx, retry_max;

  assign hpd_rise  = hpd_s2 & ~hpd_d;
  assign trig      = start | hpd_rise;
  assign cnt_tc    = (cnt == CNT_W'(PWRUP_CYCLES - 1));
  assign last_idx  = (tbl_idx == IDX_W'(NUM_ENTRIES - 1));
  assign retry_max = (retry == RTY_W'(MAX_RETRY));

  // The engine request is exactly "a write is in flight", so it follows state.
  assign eng.eng_req   = (state == TBL_WAIT) || (state == USR_WAIT);
  assign eng.eng_slave = SLAVE_ADDR;
  assign eng.eng_reg   = eng_reg_q;
  assign eng.eng_data  = eng_data_q;

  // hpd synchronizer plus a delay flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpd_s1 <= 1'b0;
      hpd_s2 <= 1'b0;
      hpd_d  <= 1'b0;
    end else begin
      hpd_s1 <= hpd;
      hpd_s2 <= hpd_s1;
      hpd_d  <= hpd_s2;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath strobes. A trigger seen while a write is in
  // flight is only remembered; the restart happens once eng_done arrives and
  // that write's result is thrown away.
  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    cnt_inc   = 1'b0;
    ld_tbl    = 1'b0;
    ld_usr    = 1'b0;
    idx_inc   = 1'b0;
    retry_inc = 1'b0;
    retry_clr = 1'b0;
    set_done  = 1'b0;
    set_err   = 1'b0;
    gnt_set   = 1'b0;
    gnt_err   = 1'b0;
    pend_set  = 1'b0;
    case (state)
      IDLE: if (trig) restart = 1'b1;
      PWR_WAIT: begin
        if (trig)         restart = 1'b1;
        else if (!hpd_s2) state_nxt = IDLE;
        else if (cnt_tc)  state_nxt = TBL_ISSUE;
        else              cnt_inc = 1'b1;
      end
      TBL_ISSUE: begin
        if (trig) restart = 1'b1;
        else begin
          ld_tbl    = 1'b1;
          state_nxt = TBL_WAIT;
        end
      end
      TBL_WAIT: begin
        if (eng.eng_done) begin
          if (pend || trig) restart = 1'b1;
          else if (!eng.eng_nack) begin
            retry_clr = 1'b1;
            if (last_idx) begin
              set_done  = 1'b1;
              state_nxt = READY;
            end else begin
              idx_inc   = 1'b1;
              state_nxt = TBL_ISSUE;
            end
          end else if (!retry_max) begin
            retry_inc = 1'b1;
            state_nxt = TBL_ISSUE;
          end else begin
            retry_clr = 1'b1;
            set_err   = 1'b1;
            state_nxt = FAIL;
          end
        end else if (trig) begin
          pend_set = 1'b1;
        end
      end
      READY: begin
        // usr_gnt still high means the requester has not yet dropped usr_req
        // for the write just completed; do not take it again.
        if (trig) restart = 1'b1;
        else if (usr_req && !usr_gnt) begin
          ld_usr    = 1'b1;
          state_nxt = USR_WAIT;
        end
      end
      USR_WAIT: begin
        if (eng.eng_done) begin
          if (pend || trig) restart = 1'b1;
          else if (!eng.eng_nack || retry_max) begin
            gnt_set   = 1'b1;
            gnt_err   = eng.eng_nack;
            retry_clr = 1'b1;
            state_nxt = READY;
          end else begin
            retry_inc = 1'b1;
            state_nxt = USR_RETRY;
          end
        end else if (trig) begin
          pend_set = 1'b1;
        end
      end
      USR_RETRY: begin
        if (trig) restart = 1'b1;
        else      state_nxt = USR_WAIT;
      end
      FAIL: if (trig) restart = 1'b1;
      default: state_nxt = IDLE;
    endcase
    if (restart) state_nxt = PWR_WAIT;
  end

  // Counters, status flags and the held engine payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      tbl_idx    <= '0;
      retry      <= '0;
      pend       <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
      usr_gnt    <= 1'b0;
      usr_err    <= 1'b0;
      eng_reg_q  <= 8'h00;
      eng_data_q <= 8'h00;
    end else begin
      if (restart) begin
        cnt      <= '0;
        tbl_idx  <= '0;
        retry    <= '0;
        pend     <= 1'b0;
        cfg_done <= 1'b0;
        cfg_err  <= 1'b0;
      end else begin
        if (cnt_inc)        cnt     <= cnt + 1'b1;
        if (idx_inc)        tbl_idx <= tbl_idx + 1'b1;
        if (retry_clr)      retry   <= '0;
        else if (retry_inc) retry   <= retry + 1'b1;
        if (pend_set)       pend     <= 1'b1;
        if (set_done)       cfg_done <= 1'b1;
        if (set_err)        cfg_err  <= 1'b1;
      end
      if (ld_tbl) begin
        eng_reg_q  <= tbl_reg;
        eng_data_q <= tbl_data;
      end else if (ld_usr) begin
        eng_reg_q  <= usr_reg;
        eng_data_q <= usr_data;
      end
      usr_gnt <= gnt_set;
      usr_err <= gnt_set & gnt_err;
    end
  end

endmodule
